// File: rtl/vga_timing_generator.sv
// vga_timing_generator
// Raster timing for a VGA-style display. Horizontal and vertical counters advance
// on the pixel strobe. Syncs and blank are delayed to line up with the framebuffer
// read latency. Framebuffer coordinates are derived by a right shift of the raw
// counters. Frame strobes and a completed-frame counter are also provided.
module vga_timing_generator #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter bit HSYNC_POL   = 1'b0,
  parameter bit VSYNC_POL   = 1'b0,
  parameter int PIPE_DELAY  = 2,
  parameter int SCALE_SHIFT = 0,
  parameter int COORD_WIDTH = 10
) (
  input  logic                   clock,
  input  logic                   reset,          // asynchronous, active low
  input  logic                   pixel_enable,
  output logic [COORD_WIDTH-1:0] pixel_x_pos,
  output logic [COORD_WIDTH-1:0] pixel_y_pos,
  output logic [COORD_WIDTH-1:0] fb_x_pos,
  output logic [COORD_WIDTH-1:0] fb_y_pos,
  output logic                   pixel_active,
  output logic                   vga_horizontal_sync,
  output logic                   vga_vertical_sync,
  output logic                   vga_blank,
  output logic                   frame_start,
  output logic                   vblank_start,
  output logic [15:0]            frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  // Counter-width constants used by the compare logic.
  localparam logic [COORD_WIDTH-1:0] H_LAST   = COORD_WIDTH'(H_TOTAL - 1);
  localparam logic [COORD_WIDTH-1:0] V_LAST   = COORD_WIDTH'(V_TOTAL - 1);
  localparam logic [COORD_WIDTH-1:0] H_ACT_C  = COORD_WIDTH'(H_ACTIVE);
  localparam logic [COORD_WIDTH-1:0] V_ACT_C  = COORD_WIDTH'(V_ACTIVE);
  localparam logic [COORD_WIDTH-1:0] HS_BEGIN = COORD_WIDTH'(H_ACTIVE + H_FRONT);
  localparam logic [COORD_WIDTH-1:0] HS_END   = COORD_WIDTH'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [COORD_WIDTH-1:0] VS_BEGIN = COORD_WIDTH'(V_ACTIVE + V_FRONT);
  localparam logic [COORD_WIDTH-1:0] VS_END   = COORD_WIDTH'(V_ACTIVE + V_FRONT + V_SYNC);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter screening
  // ---------------------------------------------------------------------------
  if (H_ACTIVE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1) begin : g_bad_h
    $error("vga_timing_generator: horizontal widths must all be at least 1");
  end
  if (V_ACTIVE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_v
    $error("vga_timing_generator: vertical widths must all be at least 1");
  end
  if (PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_bad_pipe
    $error("vga_timing_generator: PIPE_DELAY must be in 0..7");
  end
  if (SCALE_SHIFT < 0 || SCALE_SHIFT > 3) begin : g_bad_scale
    $error("vga_timing_generator: SCALE_SHIFT must be in 0..3");
  end
  if (COORD_WIDTH < 1 || COORD_WIDTH > 16) begin : g_bad_cw_range
    $error("vga_timing_generator: COORD_WIDTH must be in 1..16");
  end
  if (((H_TOTAL - 1) >> COORD_WIDTH) != 0 ||
      ((V_TOTAL - 1) >> COORD_WIDTH) != 0) begin : g_bad_cw
    $error("vga_timing_generator: COORD_WIDTH too small for H_TOTAL-1 / V_TOTAL-1");
  end

  // ---------------------------------------------------------------------------
  // Raster counters
  // ---------------------------------------------------------------------------
  logic [COORD_WIDTH-1:0] h_q, h_d;
  logic [COORD_WIDTH-1:0] v_q, v_d;
  logic [15:0]            frame_count_q, frame_count_d;
  logic                   h_wrap, v_wrap;

  assign h_wrap = (h_q == H_LAST);
  assign v_wrap = (v_q == V_LAST);

  // Next raster position: step only on an enabled pixel; wrap line, then frame.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (pixel_enable) begin
      if (h_wrap) begin
        h_d = '0;
        v_d = v_wrap ? '0 : v_q + COORD_WIDTH'(1);
      end else begin
        h_d = h_q + COORD_WIDTH'(1);
      end
    end
  end

  // Completed frames tick on the enabled pixel that wraps the bottom-right corner.
  always_comb begin
    frame_count_d = frame_count_q;
    if (pixel_enable && h_wrap && v_wrap) begin
      frame_count_d = frame_count_q + 16'd1;
    end
  end

  // Counter and frame-count state; reset restarts the raster at the top-left.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      h_q           <= '0;
      v_q           <= '0;
      frame_count_q <= '0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      frame_count_q <= frame_count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Undelayed region decode
  // ---------------------------------------------------------------------------
  logic hsync_in_range, vsync_in_range;
  logic hsync_raw, vsync_raw;
  logic [2:0] raw_vec;     // {active, vsync, hsync}
  logic [2:0] delayed_vec;

  assign pixel_active   = (h_q < H_ACT_C) && (v_q < V_ACT_C);
  assign hsync_in_range = (h_q >= HS_BEGIN) && (h_q < HS_END);
  assign vsync_in_range = (v_q >= VS_BEGIN) && (v_q < VS_END);
  assign hsync_raw      = hsync_in_range ? HSYNC_POL : ~HSYNC_POL;
  assign vsync_raw      = vsync_in_range ? VSYNC_POL : ~VSYNC_POL;
  assign raw_vec        = {pixel_active, vsync_raw, hsync_raw};

  // ---------------------------------------------------------------------------
  // Sync/blank delay line, matched to the framebuffer read latency
  // ---------------------------------------------------------------------------
  if (PIPE_DELAY == 0) begin : g_no_pipe
    assign delayed_vec = raw_vec;
  end else begin : g_pipe
    // Reset contents: blanking with both syncs at their idle level.
    localparam logic [2:0] IDLE_VEC = {1'b0, ~VSYNC_POL, ~HSYNC_POL};

    for (genvar gi = 0; gi < PIPE_DELAY; gi++) begin : g_stage
      logic [2:0] stage_q;
      logic [2:0] stage_in;

      if (gi == 0) begin : g_first
        assign stage_in = raw_vec;
      end else begin : g_chain
        assign stage_in = g_stage[gi-1].stage_q;
      end

      // One pixel of delay; the stage freezes while the pixel strobe is low.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          stage_q <= IDLE_VEC;
        end else if (pixel_enable) begin
          stage_q <= stage_in;
        end
      end
    end

    assign delayed_vec = g_stage[PIPE_DELAY-1].stage_q;
  end

  assign vga_horizontal_sync = delayed_vec[0];
  assign vga_vertical_sync   = delayed_vec[1];
  assign vga_blank           = delayed_vec[2];

  // ---------------------------------------------------------------------------
  // Coordinates, strobes and frame count
  // ---------------------------------------------------------------------------
  assign pixel_x_pos  = h_q;
  assign pixel_y_pos  = v_q;
  assign fb_x_pos     = h_q >> SCALE_SHIFT;
  assign fb_y_pos     = v_q >> SCALE_SHIFT;
  assign frame_start  = pixel_enable && (h_q == '0) && (v_q == '0);
  assign vblank_start = pixel_enable && (h_q == '0) && (v_q == V_ACT_C);
  assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_vga_timing_generator.sv
// tb_vga_timing_generator
// Directed bench. One instance uses the default 800x525 timing and checks the
// horizontal sync/blank placement through the two-stage delay. A second, tiny
// instance (8x6 total, no delay, 2:1 scale) checks frame-level behaviour, the
// strobes, pixel_enable gating and reset.
module tb_vga_timing_generator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic en_a;
  logic en_b;

  // Default-timing instance
  logic [9:0]  xa, ya, fxa, fya;
  logic        acta, hsa, vsa, bla, fsa, vba;
  logic [15:0] fca;

  // Tiny-timing instance
  logic [3:0]  xb, yb, fxb, fyb;
  logic        actb, hsb, vsb, blb, fsb, vbb;
  logic [15:0] fcb;

  int total = 0;
  int bad   = 0;

  vga_timing_generator dut_a (
    .clock               (clk),
    .reset               (rst_n),
    .pixel_enable        (en_a),
    .pixel_x_pos         (xa),
    .pixel_y_pos         (ya),
    .fb_x_pos            (fxa),
    .fb_y_pos            (fya),
    .pixel_active        (acta),
    .vga_horizontal_sync (hsa),
    .vga_vertical_sync   (vsa),
    .vga_blank           (bla),
    .frame_start         (fsa),
    .vblank_start        (vba),
    .frame_count         (fca)
  );

  vga_timing_generator #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .PIPE_DELAY(0), .SCALE_SHIFT(1), .COORD_WIDTH(4)
  ) dut_b (
    .clock               (clk),
    .reset               (rst_n),
    .pixel_enable        (en_b),
    .pixel_x_pos         (xb),
    .pixel_y_pos         (yb),
    .fb_x_pos            (fxb),
    .fb_y_pos            (fyb),
    .pixel_active        (actb),
    .vga_horizontal_sync (hsb),
    .vga_vertical_sync   (vsb),
    .vga_blank           (blb),
    .frame_start         (fsb),
    .vblank_start        (vbb),
    .frame_count         (fcb)
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  initial begin
    int a_hs_first, a_hs_line0, a_hs_last, a_hs_total, a_bl_ones, a_vs_low, a_fs_cnt;
    int b_bl_f0, b_fs_cnt, b_vb_cnt, b_vb_first;
    int fs_cnt, fs_off, unstable;
    logic [3:0] x_before;

    rst_n = 1'b0;
    en_a  = 1'b0;
    en_b  = 1'b0;
    repeat (3) @(negedge clk);

    // ---- reset state ----
    check("rst_x_a",      xa,  0);
    check("rst_y_a",      ya,  0);
    check("rst_blank_a",  bla, 0);
    check("rst_hsync_a",  hsa, 1);
    check("rst_vsync_a",  vsa, 1);
    check("rst_fcount_a", fca, 0);
    check("rst_fs_a_en0", fsa, 0);
    en_a = 1'b1;
    #1;
    check("rst_fs_a_en1", fsa, 1);

    // ---- free run from release, both instances enabled ----
    @(negedge clk);
    rst_n = 1'b1;
    en_a  = 1'b1;
    en_b  = 1'b1;
    #1;
    a_hs_first = -1; a_hs_line0 = 0; a_hs_last = -1; a_hs_total = 0;
    a_bl_ones = 0; a_vs_low = 0; a_fs_cnt = 0;
    b_bl_f0 = 0; b_fs_cnt = 0; b_vb_cnt = 0; b_vb_first = -1;
    for (int k = 0; k < 1700; k++) begin
      if (!hsa) begin
        if (a_hs_first < 0) a_hs_first = k;
        if (k < 800) a_hs_line0++;
        a_hs_last = k;
        a_hs_total++;
      end
      if (bla) a_bl_ones++;
      if (!vsa) a_vs_low++;
      if (fsa) a_fs_cnt++;
      if (k < 48 && blb) b_bl_f0++;
      if (k < 144) begin
        if (fsb) b_fs_cnt++;
        if (vbb) begin
          b_vb_cnt++;
          if (b_vb_first < 0) b_vb_first = k;
        end
      end
      if (k == 1)   check("blank_a_k1_held", bla, 0);
      if (k == 2)   check("blank_a_k2", bla, 1);
      if (k == 144) check("fcount_b_144", fcb, 3);
      if (k == 13) begin
        check("fbx_b_k13", fxb, 2);
        check("fby_b_k13", fyb, 0);
      end
      if (k == 30) begin
        check("fbx_b_k30", fxb, 3);
        check("fby_b_k30", fyb, 1);
        check("act_b_k30", actb, 0);
      end
      if (k == 9)  check("act_b_k9", actb, 1);
      if (k == 4)  check("hsync_b_k4", hsb, 1);
      if (k == 5)  check("hsync_b_k5", hsb, 0);
      if (k == 31) check("vsync_b_k31", vsb, 1);
      if (k == 32) check("vsync_b_k32", vsb, 0);
      @(negedge clk);
    end
    check("hs_a_first_low",  a_hs_first, 658);
    check("hs_a_low_line0",  a_hs_line0, 96);
    check("hs_a_last_low",   a_hs_last,  1553);
    check("hs_a_low_total",  a_hs_total, 192);
    check("blank_a_ones",    a_bl_ones,  1378);
    check("vsync_a_low",     a_vs_low,   0);
    check("fs_a_count",      a_fs_cnt,   1);
    check("blank_b_frame0",  b_bl_f0,    12);
    check("fs_b_count",      b_fs_cnt,   3);
    check("vb_b_count",      b_vb_cnt,   3);
    check("vb_b_first",      b_vb_first, 24);
    check("x_a_1700",        xa,  100);
    check("y_a_1700",        ya,  2);
    check("fcount_b_1700",   fcb, 35);

    // ---- reset mid-frame: takes effect without a clock edge ----
    check("blank_a_pre_rst", bla, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_x_a",      xa,  0);
    check("midrst_y_a",      ya,  0);
    check("midrst_blank_a",  bla, 0);
    check("midrst_hsync_a",  hsa, 1);
    check("midrst_fcount_b", fcb, 0);
    check("midrst_fbx_b",    fxb, 0);

    // ---- release; dut_b sees pixel_enable alternating 1,0 ----
    @(negedge clk);
    rst_n = 1'b1;
    fs_cnt = 0; fs_off = 0; unstable = 0;
    for (int i = 0; i < 98; i++) begin
      en_b = (i % 2 == 0);
      #1;
      if (i == 0) check("fs_a_first_after_rst", fsa, 1);
      if (fsb) fs_cnt++;
      if (!en_b && fsb) fs_off++;
      x_before = xb;
      @(negedge clk);
      if (!en_b && xb != x_before) unstable++;
    end
    check("tog_fs_count",    fs_cnt,   2);
    check("tog_fs_when_off", fs_off,   0);
    check("tog_unstable",    unstable, 0);
    check("tog_x_b",         xb,  1);
    check("tog_y_b",         yb,  0);
    check("tog_fcount_b",    fcb, 1);
    check("x_a_after_98",    xa,  98);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
